// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment driver: scans DIGITS digits, one slot of SCAN_DIV cycles each,
// with an anti-ghost blank at the start of every slot, per-digit blink and enable.
// Latency: anode/segment are pure decodes of registered state; new data shows from the next frame.
// Backpressure: ready=0 while an update is pending; load is ignored until the pending update
// commits at the next frame end.
//
// Ports:
//   clk, rst     sole clock (rising edge), synchronous active-high reset
//   data_in      4 bits per digit, digit0 in [3:0]
//   point_in     decimal point per digit (1 = lit)
//   blink_in     blink enable per digit
//   enable_in    digit enable (0 = dark)
//   load/ready   update handshake, accepted when both are 1
//   segment      {dp,g,f,e,d,c,b,a}, active-low
//   anode        digit select, active-low, at most one bit low
//   frame_tick   one-cycle pulse in the last cycle of each frame
module seg7_mux_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic [DIGITS-1:0]     enable_in,
    input  logic                  load,
    output logic                  ready,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_tick
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    // +1 keeps the width at least one bit when BLINK_FRAMES is 1
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [SW-1:0] SLOT_LAST   = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_START = SW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST    = FW'(BLINK_FRAMES - 1);

    // Scan state
    logic [SW-1:0] slot_q, slot_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;

    // Pending update (valid flag doubles as ~ready)
    logic                pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_point_q, pend_point_d;
    logic [DIGITS-1:0]   pend_blink_q, pend_blink_d;
    logic [DIGITS-1:0]   pend_en_q, pend_en_d;

    // Active (displayed) contents, only ever updated at frame end
    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_point_q, act_point_d;
    logic [DIGITS-1:0]   act_blink_q, act_blink_d;
    logic [DIGITS-1:0]   act_en_q, act_en_d;

    assign frame_tick = (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);
    assign ready      = ~pend_vld_q;

    // Segment pattern for one nibble, bits {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_d       = slot_q;
        idx_d        = idx_q;
        frm_d        = frm_q;
        phase_d      = phase_q;
        pend_vld_d   = pend_vld_q;
        pend_data_d  = pend_data_q;
        pend_point_d = pend_point_q;
        pend_blink_d = pend_blink_q;
        pend_en_d    = pend_en_q;
        act_data_d   = act_data_q;
        act_point_d  = act_point_q;
        act_blink_d  = act_blink_q;
        act_en_d     = act_en_q;

        // DIGITS need not be a power of two, so the index wraps explicitly
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            slot_d = slot_q + SW'(1);
        end

        if (frame_tick) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end

        // Commit and capture are mutually exclusive: capture needs ready (no pending),
        // commit needs a pending update. A capture in a frame_tick cycle therefore waits
        // for the following frame end.
        if (frame_tick && pend_vld_q) begin
            act_data_d  = pend_data_q;
            act_point_d = pend_point_q;
            act_blink_d = pend_blink_q;
            act_en_d    = pend_en_q;
            pend_vld_d  = 1'b0;
        end else if (load && !pend_vld_q) begin
            pend_data_d  = data_in;
            pend_point_d = point_in;
            pend_blink_d = blink_in;
            pend_en_d    = enable_in;
            pend_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            idx_q        <= '0;
            frm_q        <= '0;
            phase_q      <= 1'b1;
            pend_vld_q   <= 1'b0;
            pend_data_q  <= '0;
            pend_point_q <= '0;
            pend_blink_q <= '0;
            pend_en_q    <= '0;
            act_data_q   <= '0;
            act_point_q  <= '0;
            act_blink_q  <= '0;
            act_en_q     <= '1;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            frm_q        <= frm_d;
            phase_q      <= phase_d;
            pend_vld_q   <= pend_vld_d;
            pend_data_q  <= pend_data_d;
            pend_point_q <= pend_point_d;
            pend_blink_q <= pend_blink_d;
            pend_en_q    <= pend_en_d;
            act_data_q   <= act_data_d;
            act_point_q  <= act_point_d;
            act_blink_q  <= act_blink_d;
            act_en_q     <= act_en_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        logic [3:0] nib;
        logic       pt;
        logic       bl;
        logic       en;
        nib = '0;
        pt  = 1'b0;
        bl  = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib = act_data_q[i*4 +: 4];
                pt  = act_point_q[i];
                bl  = act_blink_q[i];
                en  = act_en_q[i];
            end
        end

        anode   = '1;
        segment = 8'hFF;
        // Dark during the blank window, when disabled, or in the off half of a blink
        if ((slot_q >= BLANK_START) && en && !(bl && !phase_q)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IW'(i)) begin
                    anode[i] = 1'b0;
                end
            end
            segment = {~pt, hex_seg(nib)};
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
module tb_seg7_mux_driver;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  point_in = '0;
    logic [3:0]  blink_in = '0;
    logic [3:0]  enable_in = '0;
    logic        load = 1'b0;
    logic        ready;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_tick;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .point_in(point_in), .blink_in(blink_in),
        .enable_in(enable_in), .load(load), .ready(ready), .segment(segment), .anode(anode),
        .frame_tick(frame_tick)
    );

    // Hex table straight from the character list (dp off)
    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: time since reset plus pending/active contents
    int          m_cyc;
    bit          m_pv;
    logic [15:0] m_pd, m_ad;
    logic [3:0]  m_pp, m_pb, m_pe, m_ap, m_ab, m_ae;

    // Expected {ready, frame_tick, anode, segment} for the current cycle
    function automatic logic [13:0] model_out();
        int         idx   = (m_cyc / SCAN_DIV) % DIGITS;
        int         slot  = m_cyc % SCAN_DIV;
        int         frame = m_cyc / FRAME;
        bit         phase = ((frame / BLINK_FRAMES) % 2) == 0;
        bit         vis   = m_ae[idx] && !(m_ab[idx] && !phase);
        logic [3:0] an    = 4'hF;
        logic [7:0] sg    = 8'hFF;
        logic [3:0] nib;
        if (vis && slot >= BLANK_CYC) begin
            an[idx] = 1'b0;
            nib = m_ad[idx*4 +: 4];
            sg = {~m_ap[idx], HEX[nib][6:0]};
        end
        return {!m_pv, (m_cyc % FRAME) == FRAME - 1, an, sg};
    endfunction

    // Apply this cycle's inputs to the model, then move to 1 time unit after the next edge
    task automatic advance();
        if (rst) begin
            m_cyc = 0; m_pv = 0;
            m_pd = '0; m_pp = '0; m_pb = '0; m_pe = '0;
            m_ad = '0; m_ap = '0; m_ab = '0; m_ae = 4'hF;
        end else begin
            if ((m_cyc % FRAME) == FRAME - 1 && m_pv) begin
                m_ad = m_pd; m_ap = m_pp; m_ab = m_pb; m_ae = m_pe; m_pv = 0;
            end else if (load && !m_pv) begin
                m_pd = data_in; m_pp = point_in; m_pb = blink_in; m_pe = enable_in; m_pv = 1;
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        advance();
        rst = 1'b0;
    endtask

    task automatic drive(input logic l, input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b, input logic [3:0] e);
        load = l; data_in = d; point_in = p; blink_in = b; enable_in = e;
    endtask

    task automatic test_reset();
        logic [13:0] exp_v;
        rst = 1'b1;
        advance();
        advance();
        tests++;
        if ({ready, frame_tick, anode, segment} !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            failed++;
            $display("FAIL reset_state got=%h want=%h", {ready, frame_tick, anode, segment},
                     {1'b1, 1'b0, 4'hF, 8'hFF});
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL reset_scan cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_handshake();
        logic [13:0] exp_v;
        logic [7:0]  want;
        bit          has;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 3)      drive(1'b1, 16'h8F30, 4'b0001, 4'b0000, 4'b1111);
            else if (i == 5) drive(1'b1, 16'h1111, 4'b0000, 4'b0000, 4'b1111);
            else             drive(1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL handshake cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            has = 1'b1;
            case (i)
                17: want = 8'h40;
                21: want = 8'hB0;
                25: want = 8'h8E;
                29: want = 8'h80;
                default: begin want = 8'hFF; has = 1'b0; end
            endcase
            if (has) begin
                tests++;
                if (segment !== want) begin
                    failed++;
                    $display("FAIL commit_digit cyc=%0d got=%h want=%h", i, segment, want);
                end
            end
            if (i == 4 || i == 15 || i == 16) begin
                tests++;
                if (ready !== (i == 16)) begin
                    failed++;
                    $display("FAIL ready_phase cyc=%0d got=%b want=%b", i, ready, (i == 16));
                end
            end
            advance();
        end
    endtask

    task automatic test_blink();
        logic [13:0] exp_v;
        do_reset();
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i == 0) drive(1'b1, 16'($urandom), 4'($urandom), 4'b0100, 4'b1111);
            else        drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL blink cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_enable();
        logic [13:0] exp_v;
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (i == 2) drive(1'b1, 16'($urandom), 4'($urandom), 4'b0000, 4'b1101);
            else        drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL enable cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            if (i >= FRAME && (i % FRAME) / SCAN_DIV == 1) begin
                tests++;
                if ({anode, segment} !== {4'hF, 8'hFF}) begin
                    failed++;
                    $display("FAIL enable_dark cyc=%0d got=%h want=fff", i, {anode, segment});
                end
            end
            advance();
        end
    endtask

    task automatic test_load_on_tick();
        logic [13:0] exp_v;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == FRAME - 1) drive(1'b1, 16'hABCD, 4'b1010, 4'b0000, 4'b1111);
            else                drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL load_on_tick cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            if (i == FRAME || i == 2 * FRAME - 1 || i == 2 * FRAME) begin
                tests++;
                if (ready !== (i == 2 * FRAME)) begin
                    failed++;
                    $display("FAIL tick_ready cyc=%0d got=%b want=%b", i, ready, (i == 2 * FRAME));
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_pending();
        logic [13:0] exp_v;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            rst = (i == 9);
            if (i == 3) drive(1'b1, 16'h5A5A, 4'b1111, 4'b0000, 4'b1111);
            else        drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL reset_pending cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            if (i == 10) begin
                tests++;
                if ({ready, anode, segment} !== {1'b1, 4'hF, 8'hFF}) begin
                    failed++;
                    $display("FAIL reset_discard got=%h want=1fff", {ready, anode, segment});
                end
            end
            if (i > 10 && anode !== 4'hF) begin
                tests++;
                if (segment !== 8'hC0) begin
                    failed++;
                    $display("FAIL pending_leak cyc=%0d got=%h want=c0", i, segment);
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [13:0] exp_v;
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom));
            exp_v = model_out();
            tests++;
            if ({ready, frame_tick, anode, segment} !== exp_v) begin
                failed++;
                $display("FAIL random cyc=%0d got=%h want=%h", i,
                         {ready, frame_tick, anode, segment}, exp_v);
            end
            advance();
        end
        rst = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_blink();
        test_enable();
        test_load_on_tick();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
